seq_pattern_gen: RTL and testbench
==================================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, the maximum pattern length in bits.
REQ-002 SHALL have parameter GAP, default 1, the number of idle cycles between repetitions (0 allowed).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load_valid  input  1  pattern-load request.
REQ-006 SHALL have port load_ready  output  1  block can accept a load; combinational, equals (state==IDLE).
REQ-007 SHALL have port pattern  input  MAX_LEN  bits to send; the active field is pattern[len-1:0].
REQ-008 SHALL have port len  input  $clog2(MAX_LEN+1)  pattern length in bits.
REQ-009 SHALL have port rep  input  4  extra repetitions; total transmissions = rep+1.
REQ-010 SHALL have port abort  input  1  synchronous cancel of the transfer in progress.
REQ-011 SHALL have port o  output  1  serial data bit, registered.
REQ-012 SHALL have port o_valid  output  1  o carries a pattern bit this cycle, registered.
REQ-013 SHALL have port busy  output  1  high in SHIFT and GAP, registered.
REQ-014 SHALL have port done  output  1  one-cycle pulse on normal completion, registered.

Function
REQ-015 SHALL use FSM states IDLE, SHIFT, GAP and DONE.
REQ-016 SHALL accept a load in IDLE when load_valid is 1: capture pattern, len and rep, then move to SHIFT.
REQ-017 SHALL clamp len>MAX_LEN to MAX_LEN at capture.
REQ-018 SHALL move directly to DONE on a capture with len==0, with no o_valid cycles.
REQ-019 SHALL present the first bit on the cycle after acceptance, i.e. one cycle of latency.
REQ-020 SHALL send MSB of the active field first, one bit per cycle: o=pattern[len-1-idx], o_valid=1, idx 0..len-1.
REQ-021 SHALL, after the last bit with repetitions remaining and GAP>0, enter GAP for exactly GAP cycles (o=0, o_valid=0, busy=1), then return to SHIFT with idx=0.
REQ-022 SHALL, after the last bit with repetitions remaining and GAP==0, start the next repetition on the very next cycle with no bubble.
REQ-023 SHALL, after the last bit of the final repetition, enter DONE for one cycle: done=1, busy=0, o_valid=0; then return to IDLE.
REQ-024 SHALL ignore load_valid outside IDLE; captured values do not change mid-transfer.
REQ-025 SHALL, on abort in SHIFT or GAP, reach IDLE on the next edge with o_valid=0, busy=0 and no done pulse; abort in IDLE or DONE has no effect.
REQ-026 SHALL give abort and rst priority over load_valid when asserted in the same cycle.
REQ-027 SHALL count repetitions down without wrap; rep=15 gives exactly 16 transmissions.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, set state=IDLE, o=0, o_valid=0, busy=0, done=0, and clear idx, repetition counter and pattern register, including mid-transfer.
REQ-029 SHALL drive load_ready=1 on the first cycle after reset release.

Structure
REQ-030 SHALL put the state enum typedef and the MAX_LEN default constant in shared package seq_gen_pkg, for reuse by the detector benches.
REQ-031 SHALL be implemented as a single module, since no sub-module is natural; bit index and repetition counter are local registers.

Verification
REQ-032 SHALL cover: pattern=8'h0D, len=4, rep=0 -> o_valid on cycles 1-4 after accept, o=1,1,0,1; done on cycle 5; load_ready on cycle 6.
REQ-033 SHALL cover: pattern=8'h0D, len=4, rep=1, GAP=2 -> 1101, 2 gap cycles with o_valid=0, 1101, done; 11 cycles from accept to done inclusive.
REQ-034 SHALL cover: len=0 -> done on cycle 1 after accept, o_valid never high; len=12 with pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1.
REQ-035 SHALL cover: abort on bit 2 of an 8-bit send -> o_valid=0 on the next cycle, no done, and a new load accepted on the cycle after.
REQ-036 SHALL cover: rst on bit 3 -> all outputs 0 on the next cycle and load_ready=1; load_valid pulsed during SHIFT -> ignored, and the original pattern completes unchanged.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator and its detector benches.
// Holds the FSM state encoding and the default pattern width.
package seq_gen_pkg;

   localparam int MAX_LEN_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serialises a captured pattern MSB-first, repeating it rep+1 times
// with GAP idle cycles between repetitions.
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int GAP     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [MAX_LEN-1:0]           pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] len,
   input  logic [3:0]                   rep,
   input  logic                         abort,
   output logic                         o,
   output logic                         o_valid,
   output logic                         busy,
   output logic                         done
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t               state_q, state_n;
   logic [LW-1:0]        idx_q, idx_n;
   logic [LW-1:0]        len_q, len_n;
   logic [3:0]           rep_q, rep_n;
   logic [MAX_LEN-1:0]   pat_q, pat_n;
   logic [GW-1:0]        gap_q, gap_n;
   logic                 o_n, valid_n, busy_n, done_n;
   logic [LW-1:0]        clen;
   logic                 last;

   function automatic logic bit_at(
      input logic [MAX_LEN-1:0] v,
      input logic [LW-1:0]      pos
   );
      return v[IW'(pos)];
   endfunction

   assign load_ready = (state_q == S_IDLE);
   assign clen = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
   assign last = (idx_q == len_q - LW'(1));

   // Output registers load the values for the state being entered,
   // so the first bit appears one cycle after acceptance.
   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      len_n   = len_q;
      rep_n   = rep_q;
      pat_n   = pat_q;
      gap_n   = gap_q;
      o_n     = 1'b0;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (load_valid && !abort) begin
               pat_n = pattern;
               len_n = clen;
               rep_n = rep;
               idx_n = '0;
               if (clen == '0) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = S_SHIFT;
                  o_n     = bit_at(pattern, clen - LW'(1));
                  valid_n = 1'b1;
                  busy_n  = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (last) begin
               if (rep_q != 4'd0) begin
                  rep_n = rep_q - 4'd1;
                  idx_n = '0;
                  busy_n = 1'b1;
                  if (GAP > 0) begin
                     state_n = S_GAP;
                     gap_n   = '0;
                  end else begin
                     o_n     = bit_at(pat_q, len_q - LW'(1));
                     valid_n = 1'b1;
                  end
               end else begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end
            end else begin
               idx_n   = idx_q + LW'(1);
               o_n     = bit_at(pat_q, len_q - LW'(2) - idx_q);
               valid_n = 1'b1;
               busy_n  = 1'b1;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (int'(gap_q) == GAP - 1) begin
               state_n = S_SHIFT;
               o_n     = bit_at(pat_q, len_q - LW'(1));
               valid_n = 1'b1;
               busy_n  = 1'b1;
            end else begin
               gap_n  = gap_q + GW'(1);
               busy_n = 1'b1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         rep_q   <= '0;
         pat_q   <= '0;
         gap_q   <= '0;
         o       <= 1'b0;
         o_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         len_q   <= len_n;
         rep_q   <= rep_n;
         pat_q   <= pat_n;
         gap_q   <= gap_n;
         o       <= o_n;
         o_valid <= valid_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: two instances (GAP=2 and GAP=0)
// share stimulus; traces are packed LSB = first cycle after accept.
module tb_seq_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic       load_ready, load_ready0;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] rep;
   logic       abort;
   logic       o, o_valid, busy, done;
   logic       o0, o_valid0, busy0, done0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_pattern_gen #(.MAX_LEN(8), .GAP(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .pattern    (pattern),
      .len        (len),
      .rep        (rep),
      .abort      (abort),
      .o          (o),
      .o_valid    (o_valid),
      .busy       (busy),
      .done       (done)
   );

   seq_pattern_gen #(.MAX_LEN(8), .GAP(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready0),
      .pattern    (pattern),
      .len        (len),
      .rep        (rep),
      .abort      (abort),
      .o          (o0),
      .o_valid    (o_valid0),
      .busy       (busy0),
      .done       (done0)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r);
      pattern    = p;
      len        = l;
      rep        = r;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
   endtask

   task automatic trace(input int n,
                        output logic [15:0] tv, output logic [15:0] to,
                        output logic [15:0] td, output logic [15:0] tb,
                        output logic [15:0] tr,
                        output logic [15:0] tv0, output logic [15:0] to0,
                        output logic [15:0] td0);
      tv = '0; to = '0; td = '0; tb = '0; tr = '0;
      tv0 = '0; to0 = '0; td0 = '0;
      for (int c = 0; c < n; c++) begin
         tv[c]  = o_valid;
         to[c]  = o;
         td[c]  = done;
         tb[c]  = busy;
         tr[c]  = load_ready;
         tv0[c] = o_valid0;
         to0[c] = o0;
         td0[c] = done0;
         step();
      end
   endtask

   logic [15:0] tv, to, td, tb, tr, tv0, to0, td0;

   initial begin
      rst = 1'b1; load_valid = 1'b0; pattern = '0;
      len = '0; rep = '0; abort = 1'b0;
      step();
      step();
      check("rst_o", o, 0);
      check("rst_valid", o_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      step();
      check("rst_ready", load_ready, 1);

      // 0x0D len 4 once: 1,1,0,1 then done, then ready
      start(8'h0D, 4'd4, 4'd0);
      trace(6, tv, to, td, tb, tr, tv0, to0, td0);
      check("t1_valid", tv, 16'h000F);
      check("t1_o", to & tv, 16'h000B);
      check("t1_done", td, 16'h0010);
      check("t1_busy", tb, 16'h000F);
      check("t1_ready", tr, 16'h0020);

      // rep=1: GAP=2 gives 11 cycles to done; GAP=0 back-to-back
      start(8'h0D, 4'd4, 4'd1);
      trace(11, tv, to, td, tb, tr, tv0, to0, td0);
      check("t2_valid", tv, 16'h03CF);
      check("t2_o", to & tv, 16'h02CB);
      check("t2_done", td, 16'h0400);
      check("t2_busy", tb, 16'h03FF);
      check("t2_g0_valid", tv0, 16'h00FF);
      check("t2_g0_o", to0 & tv0, 16'h00BB);
      check("t2_g0_done", td0, 16'h0100);

      // len=0: immediate done, no data
      start(8'hFF, 4'd0, 4'd3);
      trace(3, tv, to, td, tb, tr, tv0, to0, td0);
      check("t3_valid", tv, 16'h0000);
      check("t3_done", td, 16'h0001);

      // len=12 clamps to 8
      start(8'hA5, 4'd12, 4'd0);
      trace(10, tv, to, td, tb, tr, tv0, to0, td0);
      check("t4_valid", tv, 16'h00FF);
      check("t4_o", to & tv, 16'h00A5);
      check("t4_done", td, 16'h0100);

      // abort while presenting bit 2
      start(8'hB6, 4'd8, 4'd3);
      step();
      step();
      check("t5_bit2_valid", o_valid, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t5_valid", o_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_ready", load_ready, 1);
      start(8'h0D, 4'd4, 4'd0);
      trace(6, tv, to, td, tb, tr, tv0, to0, td0);
      check("t5_new_valid", tv, 16'h000F);
      check("t5_new_o", to & tv, 16'h000B);
      check("t5_new_done", td, 16'h0010);

      // reset while presenting bit 3
      start(8'hFF, 4'd8, 4'd2);
      step();
      step();
      step();
      check("t6_bit3_valid", o_valid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_o", o, 0);
      check("t6_valid", o_valid, 0);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_ready", load_ready, 1);

      // load_valid pulse mid-transfer is ignored
      start(8'h0D, 4'd4, 4'd0);
      tv = '0; to = '0; td = '0;
      for (int c = 0; c < 6; c++) begin
         tv[c] = o_valid;
         to[c] = o;
         td[c] = done;
         if (c == 1) begin
            pattern    = 8'hF0;
            len        = 4'd2;
            load_valid = 1'b1;
         end else begin
            load_valid = 1'b0;
         end
         step();
      end
      load_valid = 1'b0;
      check("t7_valid", tv, 16'h000F);
      check("t7_o", to & tv, 16'h000B);
      check("t7_done", td, 16'h0010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
